// File: rtl/cnn_win3x3_gen_pkg.sv
// -----------------------------------------------------------------------------
// cnn_win3x3_gen_pkg
// Shared constants for the 3x3 CNN window generator:
//   W_SIZE  - bit width of row/col/width/height (matches the frame controller)
//   W_DATA  - pixel bit width
//   WIN_K   - window edge length (3)
//   WIN_N   - number of window elements (9)
//   idx()   - flat element index of window position (i = row, j = col)
// -----------------------------------------------------------------------------
package cnn_win3x3_gen_pkg;

   localparam int W_SIZE = 12;
   localparam int W_DATA = 8;
   localparam int WIN_K  = 3;
   localparam int WIN_N  = WIN_K * WIN_K;

   // Element (i, j) of the window lives at [W_DATA*idx(i,j) +: W_DATA].
   function automatic int idx(input int i, input int j);
      return WIN_K * i + j;
   endfunction

endpackage

// File: rtl/cnn_win3x3_gen_if.sv
// -----------------------------------------------------------------------------
// cnn_win3x3_gen_if
// Raster stream bundle used both for the incoming pixel stream and for the
// outgoing window stream (payload width differs per instance).
//   vld        - beat valid (single-cycle qualifier, no backpressure)
//   data       - payload (one pixel, or a packed 3x3 window)
//   row, col   - coordinates of the beat (pixel position or window anchor)
//   end_frame  - qualifies the last beat of a frame
// Modports: master drives the bundle, slave observes it.
// -----------------------------------------------------------------------------
interface cnn_win3x3_gen_if #(
   parameter int W_SIZE = cnn_win3x3_gen_pkg::W_SIZE,
   parameter int W_PAY  = cnn_win3x3_gen_pkg::W_DATA
);

   logic              vld;
   logic [W_PAY-1:0]  data;
   logic [W_SIZE-1:0] row;
   logic [W_SIZE-1:0] col;
   logic              end_frame;

   modport master (output vld, data, row, col, end_frame);
   modport slave  (input  vld, data, row, col, end_frame);

endinterface

// File: rtl/cnn_win3x3_gen_line_buf.sv
// -----------------------------------------------------------------------------
// cnn_win3x3_gen_line_buf
// Simple dual-port line-buffer RAM, synchronous read, read-first on a
// same-address read/write in one cycle.
//   clk, rst  - clock, synchronous active-high reset (read register only)
//   we, waddr, wdata - write port
//   re, raddr, rdata - read port; rdata updates one edge after re, else holds
// -----------------------------------------------------------------------------
module cnn_win3x3_gen_line_buf #(
   parameter  int DEPTH  = 4096,
   parameter  int W_DATA = 8,
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [W_DATA-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [W_DATA-1:0] rdata
);

   logic [W_DATA-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto block RAM; stale
   // contents are harmless because the window output is gated by row/col.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // NOTE: non-blocking write and read of the same word in the same edge
   // returns the old word, which is exactly the read-first behaviour needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/cnn_win3x3_gen.sv
// -----------------------------------------------------------------------------
// cnn_win3x3_gen
// Builds a fully populated 3x3 window for every pixel position of a valid
// (unpadded) 3x3 convolution from a raster pixel stream. Two line buffers
// hold rows r-1 and r-2; a 3x3 register array slides one column per pixel.
//   clk         - clock
//   rst         - synchronous reset, active-high (wins over a valid pixel)
//   q_width     - frame width in pixels (static during a frame)
//   q_height    - frame height in pixels (static during a frame)
//   pix_stream  - slave: pixel valid / value / row / col / end-of-frame
//   win_stream  - master: window valid / packed 3x3 window / anchor row /
//                 anchor col / last window of frame
// Latency: pixel sampled at edge k -> its window is visible after edge k+2,
// independent of gaps in the input stream.
// -----------------------------------------------------------------------------
module cnn_win3x3_gen #(
   parameter int W_SIZE = cnn_win3x3_gen_pkg::W_SIZE,
   parameter int W_DATA = cnn_win3x3_gen_pkg::W_DATA,
   parameter int MAX_W  = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W_SIZE-1:0] q_width,
   input  logic [W_SIZE-1:0] q_height,
   cnn_win3x3_gen_if.slave   pix_stream,
   cnn_win3x3_gen_if.master  win_stream
);

   import cnn_win3x3_gen_pkg::*;

   localparam int                AW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [W_SIZE-1:0] TWO = W_SIZE'(2);

   // ---------------------------------------------------------------- stage 1
   logic [AW-1:0]     lb_addr;
   logic [W_DATA-1:0] rd0;        // row r-1 at the current column
   logic [W_DATA-1:0] rd1;        // row r-2 at the current column
   logic              vld_d1;
   logic [W_DATA-1:0] pix_d1;
   logic [W_SIZE-1:0] row_d1;
   logic [W_SIZE-1:0] col_d1;
   logic              end_d1;

   assign lb_addr = pix_stream.col[AW-1:0];

   // LB0 keeps the previous row: written with the incoming pixel.
   cnn_win3x3_gen_line_buf #(
      .DEPTH  (MAX_W),
      .W_DATA (W_DATA)
   ) u_lb0 (
      .clk   (clk),
      .rst   (rst),
      .we    (pix_stream.vld),
      .waddr (lb_addr),
      .wdata (pix_stream.data),
      .re    (pix_stream.vld),
      .raddr (lb_addr),
      .rdata (rd0)
   );

   // LB1 keeps the row before that. Its write data is the word LB0 held
   // before being overwritten; with a sync-read LB0 that word only exists
   // one cycle later, so the LB1 write trails by one cycle at col_d1. The
   // same column is not revisited within one cycle for any width >= 3, so
   // the delayed write is never observed early.
   cnn_win3x3_gen_line_buf #(
      .DEPTH  (MAX_W),
      .W_DATA (W_DATA)
   ) u_lb1 (
      .clk   (clk),
      .rst   (rst),
      .we    (vld_d1),
      .waddr (col_d1[AW-1:0]),
      .wdata (rd0),
      .re    (pix_stream.vld),
      .raddr (lb_addr),
      .rdata (rd1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_d1 <= 1'b0;
         pix_d1 <= '0;
         row_d1 <= '0;
         col_d1 <= '0;
         end_d1 <= 1'b0;
      end else begin
         vld_d1 <= pix_stream.vld;
         if (pix_stream.vld) begin
            pix_d1 <= pix_stream.data;
            row_d1 <= pix_stream.row;
            col_d1 <= pix_stream.col;
            end_d1 <= pix_stream.end_frame;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   // win[i][j]: i = 0 is the top row (r-2), j = 2 is the newest column.
   logic [W_DATA-1:0]       win [WIN_K][WIN_K];
   logic                    vld_d2;
   logic [W_SIZE-1:0]       row_d2;
   logic [W_SIZE-1:0]       col_d2;
   logic                    end_d2;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_d2 <= 1'b0;
         row_d2 <= '0;
         col_d2 <= '0;
         end_d2 <= 1'b0;
         for (int i = 0; i < WIN_K; i++) begin
            for (int j = 0; j < WIN_K; j++) begin
               win[i][j] <= '0;
            end
         end
      end else begin
         vld_d2 <= vld_d1;
         if (vld_d1) begin
            row_d2 <= row_d1;
            col_d2 <= col_d1;
            end_d2 <= end_d1;
            for (int i = 0; i < WIN_K; i++) begin
               for (int j = 0; j < WIN_K - 1; j++) begin
                  win[i][j] <= win[i][j+1];
               end
            end
            win[0][WIN_K-1] <= rd1;
            win[1][WIN_K-1] <= rd0;
            win[2][WIN_K-1] <= pix_d1;
         end
      end
   end

   // Flatten the register array into the output element order.
   logic [WIN_N*W_DATA-1:0] win_flat;

   // NOTE: every combinational output gets a default before the loops so no
   // path through the block leaves it unassigned (no latch).
   always_comb begin
      win_flat = '0;
      for (int i = 0; i < WIN_K; i++) begin
         for (int j = 0; j < WIN_K; j++) begin
            win_flat[idx(i, j)*W_DATA +: W_DATA] = win[i][j];
         end
      end
   end

   // A window is complete once the newest pixel is at row >= 2 and col >= 2;
   // earlier columns/rows only prime the array and line buffers. Beats with
   // coordinates outside the programmed frame are never turned into windows.
   logic in_frame;
   logic win_ok;

   assign in_frame = (row_d2 < q_height) && (col_d2 < q_width);
   assign win_ok   = vld_d2 && (row_d2 >= TWO) && (col_d2 >= TWO) && in_frame;

   // ----------------------------------------------------------- output regs
   logic                    out_vld;
   logic [WIN_N*W_DATA-1:0] out_win;
   logic [W_SIZE-1:0]       out_row;
   logic [W_SIZE-1:0]       out_col;
   logic                    out_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld <= 1'b0;
         out_win <= '0;
         out_row <= '0;
         out_col <= '0;
         out_end <= 1'b0;
      end else begin
         out_vld <= win_ok;
         out_end <= win_ok && end_d2;
         // Data and anchor hold between windows; the subtraction only ever
         // sees values >= 2, so it cannot wrap.
         if (win_ok) begin
            out_win <= win_flat;
            out_row <= row_d2 - TWO;
            out_col <= col_d2 - TWO;
         end
      end
   end

   assign win_stream.vld       = out_vld;
   assign win_stream.data      = out_win;
   assign win_stream.row       = out_row;
   assign win_stream.col       = out_col;
   assign win_stream.end_frame = out_end;

endmodule

// File: tb/tb_cnn_win3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_cnn_win3x3_gen
// Self-checking bench for cnn_win3x3_gen. A reference model keeps the frame
// as a 2-D array; every pixel at row>=2, col>=2 queues the window made of the
// 3x3 neighbourhood ending at it, with the cycle it must appear on. A monitor
// records every observed window and the two queues are compared.
// -----------------------------------------------------------------------------
module tb_cnn_win3x3_gen;

   localparam int W_SIZE = 12;
   localparam int W_DATA = 8;
   localparam int MAX_W  = 64;
   localparam int W_WIN  = 9 * W_DATA;

   typedef struct {
      logic [W_WIN-1:0] win;
      int               row;
      int               col;
      bit               end_frame;
      int               stamp;
   } win_rec_t;

   typedef struct {
      string name;
      int    w;
      int    h;
      int    base;
      int    gp;       // idle cycles between pixels of a row
      int    gr;       // idle cycles between rows
      int    exp_win;
      int    exp_end;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [W_SIZE-1:0] q_width;
   logic [W_SIZE-1:0] q_height;

   cnn_win3x3_gen_if #(.W_SIZE(W_SIZE), .W_PAY(W_DATA)) pix_if ();
   cnn_win3x3_gen_if #(.W_SIZE(W_SIZE), .W_PAY(W_WIN))  win_if ();

   cnn_win3x3_gen #(
      .W_SIZE (W_SIZE),
      .W_DATA (W_DATA),
      .MAX_W  (MAX_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .q_width    (q_width),
      .q_height   (q_height),
      .pix_stream (pix_if),
      .win_stream (win_if)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   win_rec_t   exp_q[$];
   win_rec_t   obs_q[$];
   logic [7:0] frame_pix [0:15][0:63];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_stray = 0;

   // ------------------------------------------------------------- monitor
   always @(negedge clk) begin
      win_rec_t o;
      if (win_if.vld) begin
         o.win       = win_if.data;
         o.row       = int'(win_if.row);
         o.col       = int'(win_if.col);
         o.end_frame = win_if.end_frame;
         o.stamp     = edge_cnt;
         obs_q.push_back(o);
      end
      if (win_if.end_frame && !win_if.vld) n_stray++;
   end

   // ------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Window of the row*16+col test pattern anchored at (r0, c0).
   function automatic logic [W_WIN-1:0] pat_win(input int base, input int r0, input int c0);
      logic [W_WIN-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[(3*i+j)*8 +: 8] = 8'(base + (r0 + i) * 16 + c0 + j);
      return w;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         pix_if.vld       = 1'b0;
         pix_if.end_frame = 1'b0;
      end
   endtask

   task automatic send_pix(input int r, input int c, input int w, input int h, input logic [7:0] v);
      win_rec_t e;
      @(posedge clk); #1;
      pix_if.vld       = 1'b1;
      pix_if.data      = v;
      pix_if.row       = W_SIZE'(r);
      pix_if.col       = W_SIZE'(c);
      pix_if.end_frame = (r == h - 1) && (c == w - 1);
      frame_pix[r][c]  = v;
      if (r >= 2 && c >= 2) begin
         e.win = '0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               e.win[(3*i+j)*8 +: 8] = frame_pix[r-2+i][c-2+j];
         e.row       = r - 2;
         e.col       = c - 2;
         e.end_frame = (r == h - 1) && (c == w - 1);
         e.stamp     = edge_cnt + 3;  // sampled next edge, visible two edges later
         exp_q.push_back(e);
      end
   endtask

   task automatic send_frame(input int w, input int h, input int base, input bit rnd,
                             input int gp, input int gr);
      q_width  = W_SIZE'(w);
      q_height = W_SIZE'(h);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            send_pix(r, c, w, h, rnd ? 8'($urandom) : 8'(base + r * 16 + c));
            if (c < w - 1) idle(gp);
            else if (r < h - 1) idle(gr);
         end
      end
   endtask

   function automatic int count_ends();
      int n = 0;
      foreach (obs_q[i]) if (obs_q[i].end_frame) n++;
      return n;
   endfunction

   task automatic compare_to_model(input string tag);
      int n;
      check({tag, " window count vs model"}, 128'(obs_q.size()), 128'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s win #%0d data", tag, i), 128'(obs_q[i].win), 128'(exp_q[i].win));
         check($sformatf("%s win #%0d anchor", tag, i),
               {64'(obs_q[i].row), 64'(obs_q[i].col)}, {64'(exp_q[i].row), 64'(exp_q[i].col)});
         check($sformatf("%s win #%0d end_frame", tag, i),
               128'(obs_q[i].end_frame), 128'(exp_q[i].end_frame));
         check($sformatf("%s win #%0d latency stamp", tag, i),
               128'(obs_q[i].stamp), 128'(exp_q[i].stamp));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " o_win_vld"},   128'(win_if.vld),       128'(0));
      check({tag, " o_win"},       128'(win_if.data),      128'(0));
      check({tag, " o_row"},       128'(win_if.row),       128'(0));
      check({tag, " o_col"},       128'(win_if.col),       128'(0));
      check({tag, " o_end_frame"}, 128'(win_if.end_frame), 128'(0));
   endtask

   // ------------------------------------------------------------ watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      vec_t       vecs[6];
      logic [W_WIN-1:0] got;
      bit         found;

      vecs[0] = '{"4x4 no gaps",   4,  4, 0, 0,  0,   4, 1};
      vecs[1] = '{"4x4 gaps",      4,  4, 0, 3, 10,   4, 1};
      vecs[2] = '{"3x3",           3,  3, 0, 0,  0,   1, 1};
      vecs[3] = '{"2x5",           2,  5, 0, 0,  0,   0, 0};
      vecs[4] = '{"5x2",           5,  2, 0, 0,  0,   0, 0};
      vecs[5] = '{"64x4",         64,  4, 0, 0,  0, 124, 1};

      rst              = 1'b1;
      q_width          = '0;
      q_height         = '0;
      pix_if.vld       = 1'b0;
      pix_if.data      = '0;
      pix_if.row       = '0;
      pix_if.col       = '0;
      pix_if.end_frame = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_outputs_zero("reset state");

      // Table-driven frames.
      for (int t = 0; t < 6; t++) begin
         send_frame(vecs[t].w, vecs[t].h, vecs[t].base, 1'b0, vecs[t].gp, vecs[t].gr);
         idle(6);
         check({vecs[t].name, " windows"},   128'(obs_q.size()), 128'(vecs[t].exp_win));
         check({vecs[t].name, " end_frame pulses"}, 128'(count_ends()), 128'(vecs[t].exp_end));
         if (vecs[t].exp_win > 0 && obs_q.size() > 0)
            check({vecs[t].name, " first window"}, 128'(obs_q[0].win), 128'(pat_win(vecs[t].base, 0, 0)));
         if (vecs[t].w == 64) begin
            found = 1'b0;
            got   = '0;
            foreach (obs_q[i]) begin
               if (obs_q[i].row == 1 && obs_q[i].col == 61) begin
                  found = 1'b1;
                  got   = obs_q[i].win;
               end
            end
            check("64x4 anchor (1,61) present", 128'(found), 128'(1));
            check("64x4 anchor (1,61) window", 128'(got), 128'(pat_win(0, 1, 61)));
         end
         compare_to_model(vecs[t].name);
      end

      // Back-to-back frames, frame 2 offset by 100.
      send_frame(4, 4, 0, 1'b0, 0, 0);
      send_frame(4, 4, 100, 1'b0, 0, 0);
      idle(6);
      check("b2b windows", 128'(obs_q.size()), 128'(8));
      check("b2b end_frame pulses", 128'(count_ends()), 128'(2));
      if (obs_q.size() > 4)
         check("b2b frame2 first window", 128'(obs_q[4].win), 128'(pat_win(100, 0, 0)));
      compare_to_model("b2b");

      // Reset asserted together with pixel (2,1) of a 4x4 frame.
      q_width  = 12'd4;
      q_height = 12'd4;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++)
            if (r < 2 || c < 1) send_pix(r, c, 4, 4, 8'(r * 16 + c));
      @(posedge clk); #1;
      rst              = 1'b1;
      pix_if.vld       = 1'b1;
      pix_if.data      = 8'(2 * 16 + 1);
      pix_if.row       = 12'd2;
      pix_if.col       = 12'd1;
      pix_if.end_frame = 1'b0;
      @(posedge clk); #1;
      rst        = 1'b0;
      pix_if.vld = 1'b0;
      @(negedge clk);
      check_outputs_zero("after mid-frame reset");
      idle(4);
      check("dropped frame windows", 128'(obs_q.size()), 128'(0));
      exp_q.delete();
      obs_q.delete();
      send_frame(4, 4, 0, 1'b0, 0, 0);
      idle(6);
      check("post-reset windows", 128'(obs_q.size()), 128'(4));
      if (obs_q.size() > 0)
         check("post-reset first window", 128'(obs_q[0].win), 128'(pat_win(0, 0, 0)));
      compare_to_model("post-reset");

      // Random frames: random sizes, pixel values and gaps.
      for (int k = 0; k < 8; k++) begin
         send_frame(int'($urandom_range(12, 1)), int'($urandom_range(8, 1)), 0, 1'b1,
                    int'($urandom_range(3, 0)), int'($urandom_range(5, 0)));
         idle(6);
         compare_to_model($sformatf("random frame %0d", k));
      end

      check("stray end_frame pulses", 128'(n_stray), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
